// File: rtl/stochastic_multiplier_array.sv
// Array of stochastic-computing multipliers (AND/XNOR) with optional b-stream
// decorrelation delay and per-lane ones counters over a programmable frame.
module stochastic_multiplier_array #(
    parameter int LANES        = 4,
    parameter int FRAME_W      = 8,
    parameter int DECORR_DEPTH = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic                       start,
    input  logic [FRAME_W-1:0]         frame_len,
    input  logic [LANES-1:0]           a_bits,
    input  logic [LANES-1:0]           b_bits,
    output logic [LANES-1:0]           result_bits,
    output logic                       busy,
    output logic                       done,
    output logic [LANES*FRAME_W-1:0]   counts
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic               mode_q;
    logic [FRAME_W-1:0] remaining;
    logic [LANES-1:0]   bd_p0;
    logic [LANES-1:0]   prod_p0;

    // Unipolar encoding multiplies with AND, bipolar with XNOR.
    function automatic logic [LANES-1:0] sc_product(input logic bipolar,
                                                    input logic [LANES-1:0] a,
                                                    input logic [LANES-1:0] b);
        sc_product = bipolar ? ~(a ^ b) : (a & b);
    endfunction

    // Stage p0: decorrelation delay on b, then combinational product.
    generate
        if (DECORR_DEPTH == 0) begin : g_bypass
            assign bd_p0 = b_bits;
        end else begin : g_delay
            logic [LANES-1:0] dly_p0 [DECORR_DEPTH];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < DECORR_DEPTH; k++) dly_p0[k] <= '0;
                end else begin
                    dly_p0[0] <= b_bits;
                    for (int k = 1; k < DECORR_DEPTH; k++) dly_p0[k] <= dly_p0[k-1];
                end
            end

            assign bd_p0 = dly_p0[DECORR_DEPTH-1];
        end
    endgenerate

    assign prod_p0 = sc_product(mode_q, a_bits, bd_p0);

    // Stage p1: registered product stream, free-running in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_bits <= '0;
        end else begin
            result_bits <= prod_p0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            remaining <= '0;
            counts    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        remaining <= frame_len;
                        counts    <= '0;
                        state     <= (frame_len != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    // Counts cannot wrap: frame_len never exceeds the counter range.
                    for (int i = 0; i < LANES; i++) begin
                        counts[i*FRAME_W +: FRAME_W] <= counts[i*FRAME_W +: FRAME_W]
                                                        + {{(FRAME_W-1){1'b0}}, prod_p0[i]};
                    end
                    remaining <= remaining - {{(FRAME_W-1){1'b0}}, 1'b1};
                    if (remaining == {{(FRAME_W-1){1'b0}}, 1'b1}) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: doc/stochastic_multiplier_array.md
STOCHASTIC_MULTIPLIER_ARRAY -- requirements
Module: stochastic_multiplier_array

Interface
REQ-001 Parameter LANES, default 4, number of independent multiplier lanes (>=1).
REQ-002 Parameter FRAME_W, default 8, width of frame length and per-lane counters (>=2).
REQ-003 Parameter DECORR_DEPTH, default 0, cycles of delay applied to every b stream (0 = bypass).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-006 mode  input  1  0 = unipolar (AND), 1 = bipolar (XNOR); sampled on start acceptance.
REQ-007 start  input  1  single-cycle frame request; accepted only in IDLE.
REQ-008 frame_len  input  FRAME_W  number of product bits to count; sampled on start acceptance.
REQ-009 a_bits  input  LANES  a bitstream per lane, bit i = lane i.
REQ-010 b_bits  input  LANES  b bitstream per lane, bit i = lane i.
REQ-011 result_bits  output  LANES  registered product bitstream per lane.
REQ-012 busy  output  1  high in RUN and DONE.
REQ-013 done  output  1  one-cycle pulse at frame end.
REQ-014 counts  output  LANES*FRAME_W  per-lane ones count; lane i at [i*FRAME_W +: FRAME_W].

Function
REQ-015 bd[i] SHALL be b_bits[i] delayed by exactly DECORR_DEPTH cycles via a free-running shift register per lane; DECORR_DEPTH=0 SHALL make bd = b_bits combinationally.
REQ-016 Product p[i] SHALL be a_bits[i] & bd[i] when mode_q=0, ~(a_bits[i] ^ bd[i]) when mode_q=1.
REQ-017 mode_q SHALL load from mode on start acceptance and hold otherwise.
REQ-018 result_bits SHALL register p every cycle in all states (latency 1 cycle from a_bits/bd).
REQ-019 FSM states IDLE, RUN, DONE; IDLE->RUN on start with frame_len!=0; IDLE->DONE on start with frame_len=0; RUN->DONE when last counted cycle completes; DONE->IDLE unconditionally after one cycle.
REQ-020 On start acceptance counts SHALL clear to 0 and remaining counter SHALL load frame_len.
REQ-021 In RUN, each cycle counts lane i SHALL increment by p[i] and remaining SHALL decrement by 1; exit to DONE on the cycle remaining=1 is consumed, so exactly frame_len cycles are counted, first being the cycle after start.
REQ-022 Counters SHALL not wrap: maximum frame_len 2^FRAME_W-1 bounds every count.
REQ-023 done SHALL be high exactly in DONE; counts SHALL hold their final value from DONE until the next start acceptance.
REQ-024 start in RUN or DONE SHALL be ignored with no effect on mode_q, frame_len, counts or state.
REQ-025 frame_len=0 SHALL yield done one cycle after start with all counts 0.
REQ-026 Changes on mode or frame_len while busy SHALL not affect the running frame.

Reset
REQ-027 rst=0 SHALL asynchronously force state IDLE, busy=0, done=0, result_bits=0, counts=0, remaining=0, mode_q=0, all delay registers 0.
REQ-028 Reset asserted mid-frame SHALL abort it with no done pulse; first start after rst returns high SHALL be accepted normally.

Verification (LANES=4, FRAME_W=8)
REQ-029 DECORR_DEPTH=0, mode=0, a=b=4'b1111 constant, frame_len=16 -> done 17 cycles after start cycle, every count=16.
REQ-030 mode=1, lane0 a=1 b=0, lane1 a=b=1, lane2 a=b=0, lane3 a=0 b=1, frame_len=10 -> counts {0,10,10,0} for lanes 0..3.
REQ-031 mode=0, a=b alternating 1,0,... in phase, frame_len=16: DECORR_DEPTH=0 -> count 8; DECORR_DEPTH=1 -> count 0.
REQ-032 frame_len=5 run, start pulsed again 2 cycles in with frame_len=200 -> ignored, done after 5 counted cycles, counts reflect 5 cycles.
REQ-033 frame_len=0 -> done next cycle, counts 0; rst=0 asserted at cycle 3 of a 20-cycle frame -> outputs 0 immediately, no done, next start with frame_len=4, a=b=1 -> counts 4.
